// File: rtl/snn_image_loader_if.sv
// rtl/snn_image_loader_if.sv - UART/RAM/core/TX handshake bundle for the SNN image loader
interface snn_image_loader_if;
  logic       rx_rdy;
  logic [7:0] rx_data;
  logic       ram_we;
  logic [9:0] ram_addr;
  logic       ram_data;
  logic       core_start;
  logic       core_done;
  logic [3:0] core_digit;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_done;
  logic       busy;
  logic       overrun;
  logic [3:0] digit_out;

  // Loader side: drives RAM writes, core start, UART transmit and status.
  modport master (
    input  rx_rdy, rx_data, core_done, core_digit, tx_done,
    output ram_we, ram_addr, ram_data, core_start, tx_start, tx_data,
    output busy, overrun, digit_out
  );

  // Environment side: UART receiver/transmitter, input RAM and SNN core.
  modport slave (
    output rx_rdy, rx_data, core_done, core_digit, tx_done,
    input  ram_we, ram_addr, ram_data, core_start, tx_start, tx_data,
    input  busy, overrun, digit_out
  );
endinterface

// File: rtl/snn_image_loader.sv
// rtl/snn_image_loader.sv - unpacks UART image bytes into the input RAM, runs the core, sends the digit
module snn_image_loader #(
  parameter int NUM_BYTES = 98,
  parameter bit TX_ASCII  = 1'b1
) (
  input logic               clk,
  input logic               rst_n,
  snn_image_loader_if.master bus
);

  typedef enum logic [2:0] {
    LOAD_WAIT,
    UNPACK,
    START,
    WAIT_DONE,
    TX,
    TX_WAIT
  } state_e;

  // Index of the final byte of an image; reaching it ends the load phase.
  localparam logic [7:0] LAST_IDX = 8'(NUM_BYTES - 1);

  state_e     state_q, state_d;
  logic [7:0] shreg_q, shreg_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] byte_idx_q, byte_idx_d;
  logic       ram_we_q, ram_we_d;
  logic [9:0] ram_addr_q, ram_addr_d;
  logic       ram_data_q, ram_data_d;
  logic       core_start_q, core_start_d;
  logic       tx_start_q, tx_start_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic       busy_q, busy_d;
  logic       overrun_q, overrun_d;
  logic [3:0] digit_q, digit_d;

  // Next-state and next-output logic; every output is registered from its _d value.
  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    bit_cnt_d    = bit_cnt_q;
    byte_idx_d   = byte_idx_q;
    ram_we_d     = 1'b0;
    ram_addr_d   = ram_addr_q;
    ram_data_d   = ram_data_q;
    core_start_d = 1'b0;
    tx_start_d   = 1'b0;
    tx_data_d    = tx_data_q;
    overrun_d    = overrun_q;
    digit_d      = digit_q;

    case (state_q)
      LOAD_WAIT: begin
        if (bus.rx_rdy) begin
          shreg_d   = bus.rx_data;
          bit_cnt_d = 3'd0;
          state_d   = UNPACK;
          // First byte of a fresh image clears the dropped-byte flag.
          if (byte_idx_q == 8'd0) overrun_d = 1'b0;
        end
      end
      UNPACK: begin
        ram_we_d   = 1'b1;
        ram_addr_d = {byte_idx_q[6:0], bit_cnt_q};
        ram_data_d = shreg_q[bit_cnt_q];
        bit_cnt_d  = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          byte_idx_d = byte_idx_q + 8'd1;
          state_d    = (byte_idx_q == LAST_IDX) ? START : LOAD_WAIT;
        end
      end
      START: begin
        core_start_d = 1'b1;
        state_d      = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (bus.core_done) begin
          digit_d = bus.core_digit;
          state_d = TX;
        end
      end
      TX: begin
        tx_start_d = 1'b1;
        tx_data_d  = TX_ASCII ? (8'h30 + {4'h0, digit_q}) : {4'h0, digit_q};
        state_d    = TX_WAIT;
      end
      TX_WAIT: begin
        if (bus.tx_done) begin
          byte_idx_d = 8'd0;
          state_d    = LOAD_WAIT;
        end
      end
      default: state_d = LOAD_WAIT;
    endcase

    // Bytes arriving while not listening are lost; remember that it happened.
    if (bus.rx_rdy && (state_q != LOAD_WAIT)) overrun_d = 1'b1;

    // busy tracks the state being entered so the registered flag matches state_q.
    busy_d = (state_d != LOAD_WAIT);
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= LOAD_WAIT;
      shreg_q      <= 8'd0;
      bit_cnt_q    <= 3'd0;
      byte_idx_q   <= 8'd0;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= 10'd0;
      ram_data_q   <= 1'b0;
      core_start_q <= 1'b0;
      tx_start_q   <= 1'b0;
      tx_data_q    <= 8'd0;
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
      digit_q      <= 4'd0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      bit_cnt_q    <= bit_cnt_d;
      byte_idx_q   <= byte_idx_d;
      ram_we_q     <= ram_we_d;
      ram_addr_q   <= ram_addr_d;
      ram_data_q   <= ram_data_d;
      core_start_q <= core_start_d;
      tx_start_q   <= tx_start_d;
      tx_data_q    <= tx_data_d;
      busy_q       <= busy_d;
      overrun_q    <= overrun_d;
      digit_q      <= digit_d;
    end
  end

  assign bus.ram_we     = ram_we_q;
  assign bus.ram_addr   = ram_addr_q;
  assign bus.ram_data   = ram_data_q;
  assign bus.core_start = core_start_q;
  assign bus.tx_start   = tx_start_q;
  assign bus.tx_data    = tx_data_q;
  assign bus.busy       = busy_q;
  assign bus.overrun    = overrun_q;
  assign bus.digit_out  = digit_q;

endmodule

// File: tb/tb_snn_image_loader.sv
// tb/tb_snn_image_loader.sv - directed bench for snn_image_loader
module tb_snn_image_loader;

  logic clk;
  logic rst_n;

  snn_image_loader_if b0 ();
  snn_image_loader_if b1 ();

  snn_image_loader #(.NUM_BYTES(98), .TX_ASCII(1'b1)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b0)
  );

  snn_image_loader #(.NUM_BYTES(2), .TX_ASCII(1'b0)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Observation counters, updated away from the rising edge.
  int         wr_cnt    = 0;
  int         base_cnt  = 0;
  int         seq_err   = 0;
  int         last_addr = -1;
  int         cs_cnt    = 0;
  int         wr_at_cs  = 0;
  int         tx_cnt    = 0;
  int         excl_err  = 0;
  int         cs1_cnt   = 0;
  int         tx1_cnt   = 0;
  logic [7:0] exp_byte  = 8'h00;

  // Monitor: checks each RAM write against the expected address/bit sequence.
  always @(negedge clk) begin
    if (b0.ram_we) begin
      if ((b0.ram_addr !== 10'(wr_cnt - base_cnt)) ||
          (b0.ram_data !== exp_byte[(wr_cnt - base_cnt) % 8]))
        seq_err++;
      last_addr = int'(b0.ram_addr);
      wr_cnt++;
    end
    if (b0.core_start) begin
      cs_cnt++;
      wr_at_cs = wr_cnt - base_cnt;
    end
    if (b0.tx_start) tx_cnt++;
    if ((int'(b0.ram_we) + int'(b0.core_start) + int'(b0.tx_start)) > 1) excl_err++;
    if (b1.core_start) cs1_cnt++;
    if (b1.tx_start) tx1_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send0(input logic [7:0] b);
    exp_byte = b;
    @(negedge clk);
    b0.rx_rdy  = 1'b1;
    b0.rx_data = b;
    @(negedge clk);
    b0.rx_rdy  = 1'b0;
    repeat (11) @(negedge clk);
  endtask

  task automatic send1(input logic [7:0] b);
    @(negedge clk);
    b1.rx_rdy  = 1'b1;
    b1.rx_data = b;
    @(negedge clk);
    b1.rx_rdy  = 1'b0;
    repeat (11) @(negedge clk);
  endtask

  // Accept one byte, then fire a second rx_rdy three cycles after the first.
  task automatic send0_with_overrun(input logic [7:0] b);
    exp_byte = b;
    @(negedge clk);
    b0.rx_rdy  = 1'b1;
    b0.rx_data = b;
    @(negedge clk);
    b0.rx_rdy  = 1'b0;
    repeat (2) @(negedge clk);
    b0.rx_rdy  = 1'b1;
    b0.rx_data = 8'hFF;
    @(negedge clk);
    b0.rx_rdy  = 1'b0;
    repeat (9) @(negedge clk);
  endtask

  task automatic pulse_done0(input logic [3:0] d);
    @(negedge clk);
    b0.core_done  = 1'b1;
    b0.core_digit = d;
    @(negedge clk);
    b0.core_done  = 1'b0;
  endtask

  task automatic pulse_tx_done0;
    @(negedge clk);
    b0.tx_done = 1'b1;
    @(negedge clk);
    b0.tx_done = 1'b0;
  endtask

  int tx_before;
  int cs_before;
  int wr_before;

  initial begin
    b0.rx_rdy = 1'b0; b0.rx_data = 8'h00; b0.core_done = 1'b0; b0.core_digit = 4'h0; b0.tx_done = 1'b0;
    b1.rx_rdy = 1'b0; b1.rx_data = 8'h00; b1.core_done = 1'b0; b1.core_digit = 4'h0; b1.tx_done = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_ram_we", b0.ram_we, 0);
    check("rst_ram_addr", b0.ram_addr, 0);
    check("rst_core_start", b0.core_start, 0);
    check("rst_tx_data", b0.tx_data, 0);
    check("rst_busy", b0.busy, 0);
    check("rst_overrun", b0.overrun, 0);
    check("rst_digit_out", b0.digit_out, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Image 1: 98 x A5 with an overrun injected during byte 1
    base_cnt = wr_cnt;
    send0(8'hA5);
    check("busy_idle_between_bytes", b0.busy, 0);
    send0_with_overrun(8'hA5);
    check("overrun_set", b0.overrun, 1);
    for (int i = 2; i < 98; i++) send0(8'hA5);
    check("img1_write_count", wr_cnt - base_cnt, 784);
    check("img1_addr_data_seq", seq_err, 0);
    check("img1_last_addr", last_addr, 783);
    check("img1_core_start_count", cs_cnt, 1);
    check("img1_core_start_after_783", wr_at_cs, 784);
    check("img1_busy_wait_done", b0.busy, 1);
    check("overrun_sticky", b0.overrun, 1);

    // Classification: digit 7 -> ASCII '7'
    tx_before = tx_cnt;
    pulse_done0(4'd7);
    check("digit_out_7", b0.digit_out, 7);
    repeat (3) @(negedge clk);
    check("tx_start_once", tx_cnt - tx_before, 1);
    check("tx_data_37", b0.tx_data, 8'h37);
    pulse_done0(4'd3);
    check("core_done_ignored_in_tx_wait", b0.digit_out, 7);
    check("tx_data_held", b0.tx_data, 8'h37);
    pulse_tx_done0();
    @(negedge clk);
    check("busy_after_tx_done", b0.busy, 0);
    check("tx_start_single_img1", tx_cnt - tx_before, 1);

    // Image 2: overrun clears on byte 0; rx during WAIT_DONE is dropped
    base_cnt = wr_cnt;
    cs_before = cs_cnt;
    send0(8'h3C);
    check("overrun_cleared_byte0", b0.overrun, 0);
    for (int i = 1; i < 98; i++) send0(8'h3C);
    check("img2_write_count", wr_cnt - base_cnt, 784);
    check("img2_addr_data_seq", seq_err, 0);
    wr_before = wr_cnt;
    @(negedge clk);
    b0.rx_rdy  = 1'b1;
    b0.rx_data = 8'h11;
    @(negedge clk);
    b0.rx_rdy  = 1'b0;
    repeat (12) @(negedge clk);
    check("wait_done_drop_no_write", wr_cnt - wr_before, 0);
    check("wait_done_drop_overrun", b0.overrun, 1);
    check("wait_done_no_restart", cs_cnt - cs_before, 1);
    tx_before = tx_cnt;
    pulse_done0(4'hC);
    repeat (3) @(negedge clk);
    check("tx_data_digit12_ascii", b0.tx_data, 8'h3C);
    check("tx_start_once_img2", tx_cnt - tx_before, 1);
    pulse_tx_done0();
    @(negedge clk);

    // Image 3: reset in the middle of unpacking byte 50
    base_cnt = wr_cnt;
    for (int i = 0; i < 50; i++) send0(8'h5A);
    exp_byte = 8'h5A;
    @(negedge clk);
    b0.rx_rdy  = 1'b1;
    b0.rx_data = 8'h5A;
    @(negedge clk);
    b0.rx_rdy  = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_ram_we", b0.ram_we, 0);
    check("midrst_ram_addr", b0.ram_addr, 0);
    check("midrst_ram_data", b0.ram_data, 0);
    check("midrst_tx_data", b0.tx_data, 0);
    check("midrst_busy", b0.busy, 0);
    check("midrst_digit_out", b0.digit_out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    base_cnt = wr_cnt;
    send0(8'hC3);
    check("after_rst_write_count", wr_cnt - base_cnt, 8);
    check("after_rst_addr_0_7", seq_err, 0);
    check("after_rst_last_addr", last_addr, 7);
    check("never_two_strobes", excl_err, 0);

    // Raw digit transmit on a two-byte instance
    send1(8'h01);
    check("raw_no_start_after_byte0", cs1_cnt, 0);
    send1(8'h02);
    check("raw_core_start", cs1_cnt, 1);
    @(negedge clk);
    b1.core_done  = 1'b1;
    b1.core_digit = 4'hC;
    @(negedge clk);
    b1.core_done  = 1'b0;
    repeat (3) @(negedge clk);
    check("raw_digit_out", b1.digit_out, 4'hC);
    check("raw_tx_data_0c", b1.tx_data, 8'h0C);
    check("raw_tx_start_once", tx1_cnt, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/snn_image_loader.md
SNN_IMAGE_LOADER -- requirements
Module: snn_image_loader

Parameters
REQ-001 SHALL have parameter NUM_BYTES, default 98, number of packed bytes per image (98 x 8 = 784 input bits).
REQ-002 SHALL have parameter TX_ASCII, default 1; 1 means tx_data = 8'h30 + digit, 0 means tx_data = {4'h0, digit}.

Interface
REQ-003 SHALL have port clk, input, 1, single clock; all logic on rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port rx_rdy, input, 1, one-cycle pulse from UART receiver; rx_data is valid that cycle.
REQ-006 SHALL have port rx_data, input, 8, received image byte.
REQ-007 SHALL have port ram_we, output, 1, write enable to the 784x1 input-unit RAM.
REQ-008 SHALL have port ram_addr, output, 10, input-unit RAM write address.
REQ-009 SHALL have port ram_data, output, 1, input-unit RAM write data.
REQ-010 SHALL have port core_start, output, 1, one-cycle start pulse to the SNN core.
REQ-011 SHALL have port core_done, input, 1, SNN core completion pulse.
REQ-012 SHALL have port core_digit, input, 4, SNN core result; valid when core_done = 1.
REQ-013 SHALL have port tx_start, output, 1, one-cycle pulse to UART transmitter.
REQ-014 SHALL have port tx_data, output, 8, byte to transmit; held stable from tx_start until tx_done.
REQ-015 SHALL have port tx_done, input, 1, UART transmitter completion pulse.
REQ-016 SHALL have port busy, output, 1, high in every state except LOAD_WAIT.
REQ-017 SHALL have port overrun, output, 1, sticky flag: a byte was dropped.
REQ-018 SHALL have port digit_out, output, 4, last classified digit, held until next core_done.

Function
REQ-019 SHALL implement states LOAD_WAIT, UNPACK, START, WAIT_DONE, TX, TX_WAIT.
REQ-020 LOAD_WAIT: on rx_rdy, SHALL capture rx_data into a shift register, clear the bit counter, and go to UNPACK.
REQ-021 UNPACK: SHALL spend exactly 8 cycles with ram_we = 1, ram_data = byte bit k (LSB first, k = 0..7), and ram_addr = byte_index*8 + k.
REQ-022 After bit 7, SHALL increment byte_index; if byte_index was NUM_BYTES-1, go to START, else return to LOAD_WAIT.
REQ-023 Last address written for an image SHALL be NUM_BYTES*8-1 (783 by default); no address above it is ever driven with ram_we = 1.
REQ-024 START: SHALL assert core_start for exactly one cycle, then go to WAIT_DONE.
REQ-025 WAIT_DONE: on core_done, SHALL latch core_digit into digit_out and go to TX; with no core_done it waits indefinitely.
REQ-026 TX: SHALL assert tx_start for one cycle with tx_data per REQ-002, then go to TX_WAIT.
REQ-027 TX_WAIT: on tx_done, SHALL clear byte_index and go to LOAD_WAIT.
REQ-028 rx_rdy in any state other than LOAD_WAIT SHALL drop the byte, set overrun, and leave state, counters and RAM unchanged.
REQ-029 overrun SHALL clear only on reset or on acceptance of byte 0 of the next image.
REQ-030 core_digit values 10-15 SHALL pass through unmodified; with TX_ASCII = 1 the transmitted value is 8'h30 + digit, 8-bit wrap.
REQ-031 core_done outside WAIT_DONE and tx_done outside TX_WAIT SHALL be ignored.
REQ-032 All outputs SHALL be registered; ram_we, core_start and tx_start are never high in the same cycle.

Reset
REQ-033 On rst_n = 0, SHALL immediately enter LOAD_WAIT and set ram_we = 0, ram_addr = 0, ram_data = 0, core_start = 0, tx_start = 0, tx_data = 0, busy = 0, overrun = 0, digit_out = 0, byte_index = 0.
REQ-034 Reset mid-UNPACK or mid-WAIT_DONE SHALL abandon the image; the next accepted byte is byte 0 at address 0.

Verification
REQ-035 Full image: 98 bytes of 8'hA5 with gaps >= 10 cycles -> 784 writes, addr 0..783, data pattern 1,0,1,0,0,1,0,1 per byte; one core_start after the write to 783.
REQ-036 Classification: core_done with core_digit = 7 -> digit_out = 7, one tx_start with tx_data = 8'h37; tx_done -> busy = 0.
REQ-037 Overrun: rx_rdy 3 cycles after a prior rx_rdy -> second byte dropped, overrun = 1, address sequence unaffected; overrun = 0 after byte 0 of the next image.
REQ-038 Busy drop: rx_rdy during WAIT_DONE -> no ram_we, overrun = 1, core_start not re-issued.
REQ-039 Reset during UNPACK of byte 50 -> all outputs at reset values; the next byte is written to addresses 0..7.
REQ-040 TX_ASCII = 0 with core_digit = 4'hC -> tx_data = 8'h0C.
